fixed2float_seq: RTL and testbench

Sequential fixed-point to floating-point converter, the inverse of the float-to-fixed path. Accepts a two's-complement fixed-point word with a runtime radix point and produces an IEEE-754-format float (single or parameterised), with overflow/underflow flags. Fixed-latency multi-cycle datapath with valid/ready handshakes on both sides; sits between fixed-point DSP stages and float consumers.

---
 rtl/fixed2float_seq.sv | 180 ++++++++++++++++++
 tb/tb_fixed2float_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed2float_seq.sv
// Sequential two's-complement fixed-point to IEEE-754 float converter.
// Build option: FIXED2FLOAT_ROUND_EN selects round-to-nearest-even over truncation.
module fixed2float_seq #(
  parameter int FLOATSIZE      = 32,
  parameter int FIXEDSIZE      = 32,
  parameter int RADIXPOINTSIZE = 8,
  parameter int EXPONENTBITS   = 8,
  parameter int MANTISSABITS   = 23
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic [FIXEDSIZE-1:0]      InFixed,
  input  logic [RADIXPOINTSIZE-1:0] InRadixPoint,
  input  logic                      InValid,
  output logic                      OutReady,
  output logic [FLOATSIZE-1:0]      OutFloat,
  output logic                      OutOverflow,
  output logic                      OutUnderflow,
  output logic                      OutValid,
  input  logic                      InReady
);

  localparam int CW   = $clog2(FIXEDSIZE);
  localparam int EW   = ((RADIXPOINTSIZE > CW) ? RADIXPOINTSIZE : CW) + 2;
  localparam int BW   = ((EW > EXPONENTBITS) ? EW : EXPONENTBITS) + 2;
  localparam int LW   = $clog2(FIXEDSIZE + 1);
  localparam int W    = FIXEDSIZE + MANTISSABITS + 1;
  localparam int BIAS = 2 ** (EXPONENTBITS - 1) - 1;
  localparam int EMAX = 2 ** EXPONENTBITS - 1;

`ifdef FIXED2FLOAT_ROUND_EN
  localparam logic RNE = 1'b1;
`else
  localparam logic RNE = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, ABS, NORM, ROUND, DONE
  } state_t;

  state_t state, stateNext;
  logic   armed;

  logic [FIXEDSIZE-1:0]      fixReg;
  logic [RADIXPOINTSIZE-1:0] radixReg;
  logic                      signReg;
  logic [FIXEDSIZE-1:0]      magReg;
  logic [FIXEDSIZE-2:0]      normReg;
  logic                      zeroReg;
  logic signed [EW-1:0]      expReg;

  logic [FIXEDSIZE-1:0]      magNext;
  logic [LW-1:0]             lzCnt;
  logic [FIXEDSIZE-1:0]      shiftedMag;
  logic signed [EW-1:0]      expNext;
  logic [W-1:0]              ext;
  logic [MANTISSABITS-1:0]   fracRaw;
  logic                      guardBit;
  logic                      stickyBit;
  logic                      incr;
  logic [MANTISSABITS:0]     fracSum;
  logic signed [EW-1:0]      expRnd;
  logic signed [BW-1:0]      biased;
  logic [FLOATSIZE-1:0]      floatNext;
  logic                      ovfNext;
  logic                      unfNext;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= stateNext;
      armed <= 1'b1;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (InValid && OutReady) stateNext = ABS;
      ABS:     stateNext = NORM;
      NORM:    stateNext = ROUND;
      ROUND:   stateNext = DONE;
      DONE:    if (InReady) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign OutReady = armed && (state == IDLE);
  assign OutValid = (state == DONE);

  always_comb begin
    magNext = fixReg[FIXEDSIZE-1] ? (~fixReg + 1'b1) : fixReg;
  end

  always_comb begin
    lzCnt = LW'(FIXEDSIZE);
    for (int i = 0; i < FIXEDSIZE; i++) begin
      if (magReg[i]) lzCnt = LW'(FIXEDSIZE - 1 - i);
    end
    shiftedMag = magReg << lzCnt;
    expNext = $signed(EW'(FIXEDSIZE - 1))
            - $signed(EW'(lzCnt))
            - $signed(EW'(radixReg));
  end

  // Zero-padded tail makes narrow inputs exact and wide ones roundable.
  always_comb begin
    ext       = {normReg, (MANTISSABITS + 2)'(0)};
    fracRaw   = ext[W-1 -: MANTISSABITS];
    guardBit  = ext[W-1-MANTISSABITS];
    stickyBit = |ext[W-2-MANTISSABITS:0];
    incr      = RNE & guardBit & (stickyBit | fracRaw[0]);
    fracSum   = {1'b0, fracRaw} + (MANTISSABITS + 1)'(incr);
    expRnd    = expReg
              + $signed({{(EW-1){1'b0}}, fracSum[MANTISSABITS]});
    biased    = $signed({{(BW-EW){expRnd[EW-1]}}, expRnd})
              + $signed(BW'(BIAS));
  end

  always_comb begin
    floatNext = '0;
    ovfNext   = 1'b0;
    unfNext   = 1'b0;
    if (zeroReg) begin
      floatNext = '0;
    end else if (biased >= $signed(BW'(EMAX))) begin
      floatNext = {signReg, {EXPONENTBITS{1'b1}},
                   {MANTISSABITS{1'b0}}};
      ovfNext   = 1'b1;
    end else if (biased <= $signed(BW'(0))) begin
      floatNext = {signReg, {(FLOATSIZE-1){1'b0}}};
      unfNext   = 1'b1;
    end else begin
      floatNext = {signReg, biased[EXPONENTBITS-1:0],
                   fracSum[MANTISSABITS-1:0]};
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      fixReg       <= '0;
      radixReg     <= '0;
      signReg      <= 1'b0;
      magReg       <= '0;
      normReg      <= '0;
      zeroReg      <= 1'b0;
      expReg       <= '0;
      OutFloat     <= '0;
      OutOverflow  <= 1'b0;
      OutUnderflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (InValid && OutReady) begin
            fixReg   <= InFixed;
            radixReg <= InRadixPoint;
          end
        end
        ABS: begin
          signReg <= fixReg[FIXEDSIZE-1];
          magReg  <= magNext;
        end
        NORM: begin
          normReg <= shiftedMag[FIXEDSIZE-2:0];
          zeroReg <= ~shiftedMag[FIXEDSIZE-1];
          expReg  <= expNext;
        end
        ROUND: begin
          OutFloat     <= floatNext;
          OutOverflow  <= ovfNext;
          OutUnderflow <= unfNext;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed2float_seq.sv
// Directed and randomized bench for fixed2float_seq.
// Reference model works on integer magnitudes and remainders, not bit slices.
module tb_fixed2float_seq;

`ifdef FIXED2FLOAT_ROUND_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        Clock;
  logic        Reset_n;
  logic [31:0] InFixed;
  logic [7:0]  InRadixPoint;
  logic        InValid;
  logic        OutReady;
  logic [31:0] OutFloat;
  logic        OutOverflow;
  logic        OutUnderflow;
  logic        OutValid;
  logic        InReady;

  logic [31:0] hFixed;
  logic [7:0]  hRadix;
  logic        hInValid;
  logic        hOutReady;
  logic [15:0] hFloat;
  logic        hOvf;
  logic        hUnf;
  logic        hOutValid;
  logic        hInReady;

  int checks   = 0;
  int failures = 0;

  fixed2float_seq dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .InFixed      (InFixed),
    .InRadixPoint (InRadixPoint),
    .InValid      (InValid),
    .OutReady     (OutReady),
    .OutFloat     (OutFloat),
    .OutOverflow  (OutOverflow),
    .OutUnderflow (OutUnderflow),
    .OutValid     (OutValid),
    .InReady      (InReady)
  );

  fixed2float_seq #(
    .FLOATSIZE    (16),
    .EXPONENTBITS (5),
    .MANTISSABITS (10)
  ) dut16 (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .InFixed      (hFixed),
    .InRadixPoint (hRadix),
    .InValid      (hInValid),
    .OutReady     (hOutReady),
    .OutFloat     (hFloat),
    .OutOverflow  (hOvf),
    .OutUnderflow (hUnf),
    .OutValid     (hOutValid),
    .InReady      (hInReady)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // value = x * 2^-radix, rounded to mb fraction bits
  function automatic logic [63:0] refConv(
    input logic [31:0] x, input int radix,
    input int eb, input int mb,
    output logic ovf, output logic unf);
    longint mag, m, rem, half;
    longint s;
    int p, e, b, sh;
    ovf = 1'b0;
    unf = 1'b0;
    mag = longint'($signed(x));
    s = (mag < 0) ? 1 : 0;
    if (mag < 0) mag = -mag;
    if (mag == 0) return 64'd0;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    e = p - radix;
    if (p <= mb) begin
      m = mag << (mb - p);
    end else begin
      sh = p - mb;
      m = mag >> sh;
      rem = mag - (m << sh);
      half = longint'(1) << (sh - 1);
      if (RNE && (rem > half || (rem == half && (m % 2) == 1)))
        m++;
      if (m == (longint'(1) << (mb + 1))) begin
        m = m >> 1;
        e++;
      end
    end
    b = e + (1 << (eb - 1)) - 1;
    if (b >= (1 << eb) - 1) begin
      ovf = 1'b1;
      return 64'(s << (eb + mb))
           | 64'(longint'((1 << eb) - 1) << mb);
    end
    if (b <= 0) begin
      unf = 1'b1;
      return 64'(s << (eb + mb));
    end
    return 64'(s << (eb + mb))
         | 64'(longint'(b) << mb)
         | 64'(m & ((longint'(1) << mb) - 1));
  endfunction

  task automatic conv(input string tag,
                      input logic [31:0] x,
                      input logic [7:0] r,
                      input logic [31:0] expF,
                      input logic expO,
                      input logic expU);
    int n;
    logic early;
    n = 0;
    while (!OutReady && n < 20) begin
      @(posedge Clock); #1;
      n++;
    end
    chk({tag, "_rdy"}, 64'(n < 20), 64'd1);
    InFixed = x;
    InRadixPoint = r;
    InValid = 1'b1;
    @(posedge Clock); #1;
    InValid = 1'b0;
    InFixed = $urandom;
    InRadixPoint = 8'($urandom);
    early = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (OutValid) early = 1'b1;
      @(posedge Clock); #1;
    end
    chk({tag, "_lat"}, 64'({early, OutValid}), 64'b01);
    chk({tag, "_flt"}, 64'(OutFloat), 64'(expF));
    chk({tag, "_flg"}, 64'({OutOverflow, OutUnderflow}),
        64'({expO, expU}));
  endtask

  task automatic conv16(input string tag,
                        input logic [31:0] x,
                        input logic [7:0] r,
                        input logic [15:0] expF,
                        input logic expO,
                        input logic expU);
    int n;
    n = 0;
    while (!hOutReady && n < 20) begin
      @(posedge Clock); #1;
      n++;
    end
    hFixed = x;
    hRadix = r;
    hInValid = 1'b1;
    @(posedge Clock); #1;
    hInValid = 1'b0;
    n = 0;
    while (!hOutValid && n < 10) begin
      @(posedge Clock); #1;
      n++;
    end
    chk({tag, "_v"}, 64'(n), 64'd3);
    chk({tag, "_flt"}, 64'(hFloat), 64'(expF));
    chk({tag, "_flg"}, 64'({hOvf, hUnf}), 64'({expO, expU}));
  endtask

  initial begin
    logic [63:0] ef;
    logic        eo, eu;
    logic [31:0] rx;
    logic [7:0]  rr;
    logic        ok;
    int          n;

    Reset_n = 1'b0;
    InFixed = '0;
    InRadixPoint = '0;
    InValid = 1'b0;
    InReady = 1'b1;
    hFixed = '0;
    hRadix = '0;
    hInValid = 1'b0;
    hInReady = 1'b1;
    #1;
    chk("rst_out", 64'({OutFloat, OutOverflow, OutUnderflow,
                        OutValid, OutReady}), 64'd0);
    #11 Reset_n = 1'b1;
    @(posedge Clock); #1;
    chk("rst_rdy", 64'(OutReady), 64'd1);

    conv("one",  32'h0001_0000, 8'd16, 32'h3F80_0000, 1'b0, 1'b0);
    conv("mone", 32'hFFFF_0000, 8'd16, 32'hBF80_0000, 1'b0, 1'b0);
    conv("min",  32'h8000_0000, 8'd16, 32'hC700_0000, 1'b0, 1'b0);
    conv("zero", 32'h0000_0000, 8'd16, 32'h0000_0000, 1'b0, 1'b0);
    conv("rnd",  32'h0100_0003, 8'd0,
         RNE ? 32'h4B80_0002 : 32'h4B80_0001, 1'b0, 1'b0);
    conv("carry", 32'h01FF_FFFF, 8'd0,
         RNE ? 32'h4C00_0000 : 32'h4BFF_FFFF, 1'b0, 1'b0);
    conv("unfp", 32'h0000_0001, 8'd200, 32'h0000_0000, 1'b0, 1'b1);
    conv("unfn", 32'hFFFF_FFFF, 8'd200, 32'h8000_0000, 1'b0, 1'b1);

    conv16("h_ovfp", 32'h0010_0000, 8'd0, 16'h7C00, 1'b1, 1'b0);
    conv16("h_ovfn", 32'hFFF0_0000, 8'd0, 16'hFC00, 1'b1, 1'b0);
    conv16("h_one", 32'h0000_0100, 8'd8, 16'h3C00, 1'b0, 1'b0);

    // Backpressure: result must hold while new operands are offered.
    InReady = 1'b0;
    InFixed = 32'h0001_0000;
    InRadixPoint = 8'd16;
    InValid = 1'b1;
    @(posedge Clock); #1;
    InValid = 1'b0;
    repeat (3) begin
      @(posedge Clock); #1;
    end
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      InValid = 1'b1;
      InFixed = $urandom;
      if (!(OutValid && !OutReady && OutFloat == 32'h3F80_0000))
        ok = 1'b0;
      @(posedge Clock); #1;
    end
    chk("bp_hold", 64'({ok, OutValid, OutFloat}),
        64'({1'b1, 1'b1, 32'h3F80_0000}));
    InValid = 1'b0;
    InReady = 1'b1;
    @(posedge Clock); #1;
    chk("bp_rel", 64'({OutValid, OutReady}), 64'b01);

    // Reset during NORM aborts the conversion.
    InFixed = 32'h0003_0000;
    InRadixPoint = 8'd16;
    InValid = 1'b1;
    @(posedge Clock); #1;
    InValid = 1'b0;
    @(posedge Clock); #1;
    Reset_n = 1'b0;
    #1;
    chk("mid_rst", 64'({OutFloat, OutOverflow, OutUnderflow,
                        OutValid, OutReady}), 64'd0);
    @(posedge Clock); #1;
    Reset_n = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge Clock); #1;
      if (OutValid) ok = 1'b0;
    end
    chk("mid_noval", 64'({ok, OutReady}), 64'b11);
    conv("post", 32'h0001_8000, 8'd16, 32'h3FC0_0000, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rx = $urandom;
      if ($urandom_range(0, 3) == 0) rx = rx >> $urandom_range(0, 31);
      rr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                       : 8'($urandom_range(0, 40));
      ef = refConv(rx, int'(rr), 8, 23, eo, eu);
      conv("rand", rx, rr, ef[31:0], eo, eu);
    end

    for (int i = 0; i < 12; i++) begin
      rx = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) rx = -rx;
      rr = 8'($urandom_range(0, 40));
      ef = refConv(rx, int'(rr), 5, 10, eo, eu);
      conv16("h_rand", rx, rr, ef[15:0], eo, eu);
    end

    n = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
